// File: rtl/text_console_ctrl_if.sv
// Bundle of keyboard, text-RAM and font-ROM signals around text_console_ctrl.
// master = the console controller, slave = the surrounding keyboard/RAM/VGA environment.
interface text_console_ctrl_if;
    logic       key_valid;
    logic [7:0] key_ascii;
    logic       key_ready;
    logic [9:0] h_addr;
    logic [9:0] v_addr;
    logic       buf_we;
    logic [11:0] buf_waddr;
    logic [7:0] buf_wdata;
    logic [11:0] buf_raddr;
    logic [7:0] buf_rdata;
    logic [7:0] glyph_ascii;
    logic [3:0] glyph_row;
    logic [3:0] glyph_col;

    modport master (
        input  key_valid, key_ascii, h_addr, v_addr, buf_rdata,
        output key_ready, buf_we, buf_waddr, buf_wdata, buf_raddr,
               glyph_ascii, glyph_row, glyph_col
    );

    modport slave (
        output key_valid, key_ascii, h_addr, v_addr, buf_rdata,
        input  key_ready, buf_we, buf_waddr, buf_wdata, buf_raddr,
               glyph_ascii, glyph_row, glyph_col
    );
endinterface

// File: rtl/text_console_ctrl.sv
// Text-mode console: keyboard-driven write/scroll/clear engine plus pixel-to-cell read pipeline.
// Optional cursor rendering is enabled by defining CURSOR_BLINK_EN.
module text_console_ctrl #(
    parameter int COLS    = 70,
    parameter int ROWS    = 30,
    parameter int CHAR_W  = 9,
    parameter int BLINK_P = 25000000
) (
    input  logic             clk,
    input  logic             reset,
    text_console_ctrl_if.master bus
);
    localparam int CELLS = COLS * ROWS;
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    if (CELLS > 4096 || CHAR_W > 16 || BLINK_P < 2) begin : g_param_check
        $error("text_console_ctrl: unsupported parameter combination");
    end

    typedef enum logic [2:0] {CLR_ALL, IDLE, WRITE, ADVANCE, CLR_LINE} state_t;

    state_t           state;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_lrow;
    logic [ROW_W-1:0] top_row;
    logic [11:0]      clr_cnt;
    logic [7:0]       key_q;
    logic             key_ready;
    logic             buf_we;
    logic [11:0]      buf_waddr;
    logic [7:0]       buf_wdata;

    // Screen line `row` lives in physical row (top + row) mod ROWS.
    function automatic logic [11:0] cell_addr(input logic [11:0] top,
                                              input logic [11:0] row,
                                              input logic [11:0] col);
        logic [11:0] phys;
        phys = top + row;
        if (phys >= 12'(ROWS)) phys = phys - 12'(ROWS);
        return phys * 12'(COLS) + col;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= CLR_ALL;
            cur_col   <= '0;
            cur_lrow  <= '0;
            top_row   <= '0;
            clr_cnt   <= '0;
            key_q     <= '0;
            key_ready <= 1'b0;
            buf_we    <= 1'b0;
            buf_waddr <= '0;
            buf_wdata <= '0;
        end else begin
            // NOTE: default-low pulse; any branch below that writes overrides it in the same edge.
            buf_we <= 1'b0;
            case (state)
                CLR_ALL: begin
                    buf_we    <= 1'b1;
                    buf_waddr <= clr_cnt;
                    buf_wdata <= 8'h20;
                    if (clr_cnt == 12'(CELLS - 1)) begin
                        clr_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 12'd1;
                    end
                end
                IDLE: begin
                    if (key_ready && bus.key_valid) begin
                        key_ready <= 1'b0;
                        key_q     <= bus.key_ascii;
                        state     <= WRITE;
                    end else begin
                        key_ready <= 1'b1;
                    end
                end
                WRITE: begin
                    state <= IDLE;
                    if (key_q >= 8'h20 && key_q <= 8'h7E) begin
                        buf_we    <= 1'b1;
                        buf_waddr <= cell_addr(12'(top_row), 12'(cur_lrow), 12'(cur_col));
                        buf_wdata <= key_q;
                        if (cur_col == LAST_COL) begin
                            cur_col <= '0;
                            state   <= ADVANCE;
                        end else begin
                            cur_col <= cur_col + COL_W'(1);
                        end
                    end else if (key_q == 8'h0A) begin
                        cur_col <= '0;
                        state   <= ADVANCE;
                    end else if (key_q == 8'h08 && cur_col != '0) begin
                        cur_col   <= cur_col - COL_W'(1);
                        buf_we    <= 1'b1;
                        buf_waddr <= cell_addr(12'(top_row), 12'(cur_lrow), 12'(cur_col) - 12'd1);
                        buf_wdata <= 8'h20;
                    end
                end
                ADVANCE: begin
                    if (cur_lrow != LAST_ROW) begin
                        cur_lrow <= cur_lrow + ROW_W'(1);
                        state    <= IDLE;
                    end else begin
                        // Scroll: the old top line becomes the new bottom line and is blanked.
                        top_row <= (top_row == LAST_ROW) ? '0 : top_row + ROW_W'(1);
                        clr_cnt <= '0;
                        state   <= CLR_LINE;
                    end
                end
                CLR_LINE: begin
                    buf_we    <= 1'b1;
                    buf_waddr <= cell_addr(12'(top_row), 12'(ROWS - 1), clr_cnt);
                    buf_wdata <= 8'h20;
                    if (clr_cnt == 12'(COLS - 1)) begin
                        clr_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        clr_cnt <= clr_cnt + 12'd1;
                    end
                end
                default: state <= CLR_ALL;
            endcase
        end
    end

    assign bus.key_ready = key_ready;
    assign bus.buf_we    = buf_we;
    assign bus.buf_waddr = buf_waddr;
    assign bus.buf_wdata = buf_wdata;

    logic [9:0] cell_col;
    logic [9:0] cell_row;
    logic [3:0] glyph_row_q;
    logic [3:0] glyph_col_q;
    logic       blank_q;

    assign cell_col      = bus.h_addr / 10'(CHAR_W);
    assign cell_row      = {4'd0, bus.v_addr[9:4]};
    assign bus.buf_raddr = cell_addr(12'(top_row), 12'(cell_row), 12'(cell_col));

    // Glyph coordinates are delayed one cycle to line up with the synchronous RAM data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glyph_row_q <= '0;
            glyph_col_q <= '0;
            blank_q     <= 1'b1;
        end else begin
            glyph_row_q <= bus.v_addr[3:0];
            glyph_col_q <= 4'(bus.h_addr % 10'(CHAR_W));
            blank_q     <= (cell_col >= 10'(COLS)) || (cell_row >= 10'(ROWS));
        end
    end

    assign bus.glyph_row = glyph_row_q;
    assign bus.glyph_col = glyph_col_q;

`ifdef CURSOR_BLINK_EN
    localparam int BLINK_W = $clog2(BLINK_P + 1);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;
    logic               cursor_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            cursor_q  <= 1'b0;
        end else begin
            if (blink_cnt == BLINK_W'(BLINK_P - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
            cursor_q <= blink_on && (cell_row == 10'(cur_lrow)) && (cell_col == 10'(cur_col));
        end
    end

    assign bus.glyph_ascii = blank_q ? 8'h00 : (cursor_q ? 8'h5F : bus.buf_rdata);
`else
    assign bus.glyph_ascii = blank_q ? 8'h00 : bus.buf_rdata;
`endif

endmodule

// File: tb/tb_text_console_ctrl.sv
// Directed bench for text_console_ctrl with a text-RAM model, a write scoreboard and a glyph scoreboard.
module tb_text_console_ctrl;
    localparam int COLS   = 70;
    localparam int ROWS   = 30;
    localparam int CHAR_W = 9;
    localparam int CELLS  = COLS * ROWS;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct {
        logic [7:0] ascii;
        logic [3:0] row;
        logic [3:0] col;
    } rd_t;

    logic clk = 1'b0;
    logic reset;

    text_console_ctrl_if bus ();

    text_console_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem     [0:CELLS-1];
    logic [7:0] exp_mem [0:CELLS-1];
    wr_t        exp_q[$];
    rd_t        rd_q[$];
    wr_t        mon_e;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_count = 0;
    int m_col    = 0;
    int m_row    = 0;
    int m_top    = 0;

    always @(posedge clk) begin
        if (bus.buf_we === 1'b1 && bus.buf_waddr < 12'(CELLS))
            mem[bus.buf_waddr] <= bus.buf_wdata;
        bus.buf_rdata <= (bus.buf_raddr < 12'(CELLS)) ? mem[bus.buf_raddr] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic int m_addr(input int r, input int c);
        return ((m_top + r) % ROWS) * COLS + c;
    endfunction

    task automatic push_wr(input int a, input logic [7:0] d);
        wr_t e;
        e.addr = 12'(a);
        e.data = d;
        exp_q.push_back(e);
        exp_mem[a] = d;
    endtask

    task automatic model_advance();
        if (m_row < ROWS - 1) begin
            m_row++;
        end else begin
            m_top = (m_top + 1) % ROWS;
            for (int c = 0; c < COLS; c++) push_wr(m_addr(ROWS - 1, c), 8'h20);
        end
    endtask

    task automatic model_key(input logic [7:0] k);
        if (k >= 8'h20 && k <= 8'h7E) begin
            push_wr(m_addr(m_row, m_col), k);
            if (m_col == COLS - 1) begin
                m_col = 0;
                model_advance();
            end else begin
                m_col++;
            end
        end else if (k == 8'h0A) begin
            m_col = 0;
            model_advance();
        end else if (k == 8'h08 && m_col > 0) begin
            m_col--;
            push_wr(m_addr(m_row, m_col), 8'h20);
        end
    endtask

    // Every write pulse must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.buf_we === 1'b1) begin
            wr_count++;
            check("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("buf_waddr", 32'(bus.buf_waddr), 32'(mon_e.addr));
                check("buf_wdata", 32'(bus.buf_wdata), 32'(mon_e.data));
            end
        end
    end

    task automatic wait_ready(input string tag, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (bus.key_ready !== 1'b1 && cycles < 5000);
        if (bus.key_ready !== 1'b1) check(tag, 32'(bus.key_ready), 1);
    endtask

    task automatic send_key(input logic [7:0] k, output int writes);
        int w0;
        int rc;
        w0            = wr_count;
        bus.key_valid = 1'b1;
        bus.key_ascii = k;
        model_key(k);
        @(negedge clk);
        bus.key_valid = 1'b0;
        check("key_ready_drop", 32'(bus.key_ready), 0);
        wait_ready("key_ready_return", rc);
        writes = wr_count - w0;
    endtask

    task automatic probe(input logic [9:0] h, input logic [9:0] v);
        int  cc;
        int  cr;
        int  a;
        rd_t e;
        rd_t got;
        bus.h_addr = h;
        bus.v_addr = v;
        cc = int'(h) / CHAR_W;
        cr = int'(v) / 16;
        a  = m_addr(cr, cc);
        #1;
        if (cc < COLS && cr < ROWS) check("buf_raddr", 32'(bus.buf_raddr), 32'(a));
        e.ascii = (cc < COLS && cr < ROWS) ? exp_mem[a] : 8'h00;
        e.row   = 4'(int'(v) % 16);
        e.col   = 4'(int'(h) % CHAR_W);
        rd_q.push_back(e);
        @(negedge clk);
        got = rd_q.pop_front();
        check("glyph_ascii", 32'(bus.glyph_ascii), 32'(got.ascii));
        check("glyph_row", 32'(bus.glyph_row), 32'(got.row));
        check("glyph_col", 32'(bus.glyph_col), 32'(got.col));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int w;
        int total;
        logic [9:0] h_tab [8] = '{10'd48, 10'd9, 10'd17, 10'd18, 10'd629, 10'd630, 10'd0, 10'd1023};
        logic [9:0] v_tab [8] = '{10'd39, 10'd5, 10'd15, 10'd0, 10'd479, 10'd0, 10'd480, 10'd1023};

        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_ascii = 8'h00;
        bus.h_addr    = 10'd0;
        bus.v_addr    = 10'd0;
        @(negedge clk);
        check("rst_key_ready", 32'(bus.key_ready), 0);
        check("rst_buf_we", 32'(bus.buf_we), 0);
        check("rst_buf_waddr", 32'(bus.buf_waddr), 0);
        check("rst_buf_wdata", 32'(bus.buf_wdata), 0);
        check("rst_glyph_ascii", 32'(bus.glyph_ascii), 0);
        check("rst_glyph_row", 32'(bus.glyph_row), 0);
        check("rst_glyph_col", 32'(bus.glyph_col), 0);

        for (int i = 0; i < CELLS; i++) push_wr(i, 8'h20);
        reset = 1'b0;
        wait_ready("clear_all_timeout", cyc);
        check("clear_all_ready_cycle", 32'(cyc), 2101);
        check("clear_all_writes", 32'(wr_count), 2100);
        check("clear_all_we_at_ready", 32'(bus.buf_we), 0);

        send_key(8'h41, w);
        check("key_41_writes", 32'(w), 1);

        total = 0;
        for (int i = 1; i < COLS; i++) begin
            send_key(8'(8'h21 + i), w);
            total += w;
        end
        check("row0_writes_no_clear", 32'(total), 69);
        send_key(8'h5A, w);
        check("wrap_next_row_write", 32'(w), 1);

        send_key(8'h08, w);
        check("bs_col1_writes", 32'(w), 1);
        send_key(8'h08, w);
        check("bs_col0_no_write", 32'(w), 0);
        send_key(8'h61, w);
        send_key(8'h62, w);
        send_key(8'h63, w);
        send_key(8'h08, w);
        check("bs_col3_writes", 32'(w), 1);
        send_key(8'h64, w);
        check("after_bs_write", 32'(w), 1);
        send_key(8'h01, w);
        check("drop_01", 32'(w), 0);
        send_key(8'h7F, w);
        check("drop_7f", 32'(w), 0);

        total = 0;
        for (int i = 0; i < ROWS - 2; i++) begin
            send_key(8'h0A, w);
            total += w;
        end
        check("newlines_no_write", 32'(total), 0);
        send_key(8'h0A, w);
        check("scroll_clear_writes", 32'(w), 70);
        check("scroll_we_at_ready", 32'(bus.buf_we), 0);
        check("writes_outstanding", 32'(exp_q.size()), 0);

        for (int i = 0; i < 8; i++) probe(h_tab[i], v_tab[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
